// File: rtl/pb1qsys_nios2_qsys_0_oci_dct_packer.sv
// Packs 3-bit OCI trace atoms into 30-bit words with a fill count, with
// valid/ready backpressure, forced flush and a lossless end-of-test drain.
module pb1qsys_nios2_qsys_0_oci_dct_packer #(
  parameter int ATOM_W = 3,
  parameter int SLOTS  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              atom_valid,
  input  logic [ATOM_W-1:0] atom,
  output logic              atom_ready,
  input  logic              flush,
  input  logic              test_end_req,
  output logic [29:0]       dct_buffer,
  output logic [3:0]        dct_count,
  output logic              dct_valid,
  input  logic              dct_ready,
  output logic              test_ending,
  output logic              test_has_ended
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] ENDING = 2'd1;
  localparam logic [1:0] ENDED  = 2'd2;
  localparam logic [3:0] FULL   = 4'(SLOTS);

  logic [1:0]  state, state_next;
  logic [29:0] acc_buf, acc_buf_next;
  logic [3:0]  acc_cnt, acc_cnt_next;
  logic        flush_pend, flush_pend_next;
  logic        accept, slot_free, transfer, end_req, flush_req;

  assign atom_ready     = (acc_cnt < FULL) && !flush_pend && (state != ENDED);
  assign accept         = atom_valid && atom_ready;
  assign slot_free      = !dct_valid || dct_ready;
  assign transfer       = slot_free && ((acc_cnt == FULL) || (flush_pend && (acc_cnt != 4'd0)));
  assign end_req        = test_end_req && (state == RUN);
  assign flush_req      = flush && (state != ENDED);
  assign test_ending    = (state == ENDING);
  assign test_has_ended = (state == ENDED);

  // A transfer and an accept never coincide: both transfer causes hold atom_ready low.
  always_comb begin
    acc_buf_next = acc_buf;
    acc_cnt_next = acc_cnt;
    if (transfer) begin
      acc_buf_next = '0;
      acc_cnt_next = 4'd0;
    end else if (accept) begin
      for (int k = 0; k < SLOTS; k++) begin
        if (acc_cnt == 4'(k)) acc_buf_next[k*ATOM_W +: ATOM_W] = atom;
      end
      acc_cnt_next = acc_cnt + 4'd1;
    end
  end

  // Entering ENDING only arms a flush when there is data to flush, so an idle
  // drain completes one edge after entry.
  always_comb begin
    flush_pend_next = flush_pend;
    if (transfer || (flush_pend && (acc_cnt == 4'd0))) flush_pend_next = 1'b0;
    if (end_req)        flush_pend_next = (acc_cnt_next != 4'd0);
    else if (flush_req) flush_pend_next = 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (test_end_req) state_next = ENDING;
      ENDING:  if ((acc_cnt == 4'd0) && !flush_pend && !dct_valid) state_next = ENDED;
      ENDED:   state_next = ENDED;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      acc_buf    <= '0;
      acc_cnt    <= 4'd0;
      flush_pend <= 1'b0;
      dct_buffer <= '0;
      dct_count  <= 4'd0;
      dct_valid  <= 1'b0;
    end else begin
      state      <= state_next;
      acc_buf    <= acc_buf_next;
      acc_cnt    <= acc_cnt_next;
      flush_pend <= flush_pend_next;
      if (transfer) begin
        dct_buffer <= acc_buf;
        dct_count  <= acc_cnt;
        dct_valid  <= 1'b1;
      end else if (dct_ready) begin
        dct_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pb1qsys_nios2_qsys_0_oci_dct_packer.sv
// Self-checking bench for the OCI trace atom packer: directed scenarios plus
// random traffic, compared every cycle against a queue-based reference model.
module tb_pb1qsys_nios2_qsys_0_oci_dct_packer;

  logic        clk, reset, atom_valid, atom_ready, flush, test_end_req;
  logic [2:0]  atom;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        dct_valid, dct_ready, test_ending, test_has_ended;

  int vectors = 0;
  int miscompares = 0;

  pb1qsys_nios2_qsys_0_oci_dct_packer dut (
    .clk(clk), .reset(reset), .atom_valid(atom_valid), .atom(atom),
    .atom_ready(atom_ready), .flush(flush), .test_end_req(test_end_req),
    .dct_buffer(dct_buffer), .dct_count(dct_count), .dct_valid(dct_valid),
    .dct_ready(dct_ready), .test_ending(test_ending), .test_has_ended(test_has_ended)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int M_RUN = 0, M_ENDING = 1, M_ENDED = 2;

  // Reference model: pending atoms as a queue, words built with base-8 arithmetic.
  int          m_acc[$];
  bit          m_fp, m_ov;
  int          m_st;
  logic [29:0] m_buf;
  logic [3:0]  m_cnt;
  bit          last_macc, last_dacc, last_hs;

  function automatic logic [29:0] pack(input int q[$]);
    longint w = 0;
    for (int k = 0; k < q.size(); k++) w += longint'(q[k]) * (longint'(8) ** k);
    return 30'(w);
  endfunction

  function automatic bit m_ready();
    return (m_acc.size() < 10) && !m_fp && (m_st != M_ENDED);
  endfunction

  task automatic model_reset();
    m_acc.delete();
    m_fp = 0; m_ov = 0; m_st = M_RUN; m_buf = '0; m_cnt = '0;
  endtask

  task automatic model_edge(input bit av, input logic [2:0] a, input bit fl, te, dr);
    bit take    = av && m_ready();
    bit xfer    = (!m_ov || dr) && ((m_acc.size() == 10) || (m_fp && m_acc.size() > 0));
    bit idle_fp = m_fp && (m_acc.size() == 0);
    bit can_end = (m_st == M_ENDING) && (m_acc.size() == 0) && !m_fp && !m_ov;
    if (xfer) begin
      m_buf = pack(m_acc);
      m_cnt = 4'(m_acc.size());
      m_ov  = 1;
      m_acc.delete();
    end else if (dr) begin
      m_ov = 0;
    end
    if (take) m_acc.push_back(int'(a));
    if (xfer || idle_fp) m_fp = 0;
    if (te && m_st == M_RUN) begin
      m_fp = (m_acc.size() > 0);
      m_st = M_ENDING;
    end else begin
      if (fl && m_st != M_ENDED) m_fp = 1;
      if (can_end) m_st = M_ENDED;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    chk("atom_ready", 32'(atom_ready), 32'(m_ready()));
    chk("dct_valid", 32'(dct_valid), 32'(m_ov));
    chk("dct_count", 32'(dct_count), 32'(m_cnt));
    chk("dct_buffer", 32'(dct_buffer), 32'(m_buf));
    chk("test_ending", 32'(test_ending), 32'(m_st == M_ENDING));
    chk("test_has_ended", 32'(test_has_ended), 32'(m_st == M_ENDED));
  endtask

  // One clock: drive at the falling edge, check, then advance DUT and model together.
  task automatic step(input bit rst, av, input logic [2:0] a, input bit fl, te, dr);
    reset = rst; atom_valid = av; atom = a; flush = fl; test_end_req = te; dct_ready = dr;
    #1;
    check_output();
    last_macc = av && m_ready();
    last_dacc = av && atom_ready;
    last_hs   = dct_valid && dr;
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(av, a, fl, te, dr);
    @(negedge clk);
  endtask

  logic [2:0] fw[10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
  logic [2:0] src[25];

  initial begin
    int idx, dacc, hs, n;
    logic [29:0] sh;
    reset = 1; atom_valid = 0; atom = '0; flush = 0; test_end_req = 0; dct_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_atom_ready", 32'(atom_ready), 32'd1);
    chk("rst_dct_valid", 32'(dct_valid), 32'd0);
    chk("rst_dct_count", 32'(dct_count), 32'd0);
    chk("rst_dct_buffer", 32'(dct_buffer), 32'd0);
    chk("rst_test_ending", 32'(test_ending), 32'd0);
    chk("rst_test_has_ended", 32'(test_has_ended), 32'd0);

    $display("[TB] full word");
    for (int i = 0; i < 10; i++) step(0, 1, fw[i], 0, 0, 1);
    chk("full_ready_gap", 32'(atom_ready), 32'd0);
    chk("full_valid_early", 32'(dct_valid), 32'd0);
    step(0, 0, 3'd0, 0, 0, 0);
    chk("full_valid", 32'(dct_valid), 32'd1);
    chk("full_count", 32'(dct_count), 32'd10);
    // slots 0..9 = 1,2,3,4,5,6,7,0,1,2 at bits [3k+2:3k]
    chk("full_buffer", 32'(dct_buffer), 32'h111F58D1);
    chk("full_ready_back", 32'(atom_ready), 32'd1);
    sh = dct_buffer;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("slot%0d", k), 32'(sh[2:0]), 32'(fw[k]));
      sh = sh >> 3;
    end
    step(0, 0, 3'd0, 0, 0, 1);
    chk("full_consumed", 32'(dct_valid), 32'd0);

    $display("[TB] flush partial");
    repeat (3) step(0, 1, 3'd5, 0, 0, 0);
    step(0, 0, 3'd0, 1, 0, 0);
    step(0, 0, 3'd0, 0, 0, 0);
    chk("flush_valid", 32'(dct_valid), 32'd1);
    chk("flush_count", 32'(dct_count), 32'd3);
    chk("flush_buffer", 32'(dct_buffer), 32'h16D);
    step(0, 0, 3'd0, 0, 0, 1);
    step(0, 0, 3'd0, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 3'd0, 0, 0, 1);
      chk("flush_empty_no_valid", 32'(dct_valid), 32'd0);
    end

    $display("[TB] backpressure");
    for (int i = 0; i < 25; i++) src[i] = 3'($urandom_range(7));
    idx = 0; dacc = 0; hs = 0;
    for (int c = 0; c < 40; c++) begin
      step(0, idx < 25, (idx < 25) ? src[idx] : 3'd0, 0, 0, 0);
      if (last_macc) idx++;
      if (last_dacc) dacc++;
    end
    chk("bp_accepted", 32'(dacc), 32'd20);
    chk("bp_ready_low", 32'(atom_ready), 32'd0);
    for (int c = 0; c < 30; c++) begin
      step(0, idx < 25, (idx < 25) ? src[idx] : 3'd0, c == 15, 0, 1);
      if (last_macc) idx++;
      if (last_hs) hs++;
    end
    chk("bp_words_delivered", 32'(hs), 32'd3);

    $display("[TB] end of test");
    repeat (2) step(1, 0, 3'd0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 3'(i + 3), 0, 0, 0);
    step(0, 0, 3'd0, 0, 1, 0);
    chk("end_ending", 32'(test_ending), 32'd1);
    chk("end_ready_low", 32'(atom_ready), 32'd0);
    step(0, 0, 3'd0, 0, 0, 0);
    chk("end_word_valid", 32'(dct_valid), 32'd1);
    chk("end_word_count", 32'(dct_count), 32'd4);
    step(0, 0, 3'd0, 0, 0, 1);
    chk("end_not_yet", 32'(test_has_ended), 32'd0);
    step(0, 0, 3'd0, 0, 0, 1);
    chk("end_has_ended", 32'(test_has_ended), 32'd1);
    repeat (3) step(0, 1, 3'd1, 1, 1, 1);
    chk("end_sticky", 32'(test_has_ended), 32'd1);

    $display("[TB] reset mid-operation");
    repeat (2) step(1, 0, 3'd0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 3'(i), 0, 0, 0);
    step(0, 0, 3'd0, 0, 0, 0);
    repeat (3) step(0, 1, 3'd6, 0, 0, 0);
    step(0, 0, 3'd0, 0, 1, 0);
    chk("mid_valid_before", 32'(dct_valid), 32'd1);
    chk("mid_ending_before", 32'(test_ending), 32'd1);
    step(1, 0, 3'd0, 0, 0, 0);
    chk("mid_valid", 32'(dct_valid), 32'd0);
    chk("mid_ending", 32'(test_ending), 32'd0);
    chk("mid_ended", 32'(test_has_ended), 32'd0);
    chk("mid_ready", 32'(atom_ready), 32'd1);

    $display("[TB] idle end");
    step(0, 0, 3'd0, 0, 1, 0);
    chk("idle_ending", 32'(test_ending), 32'd1);
    step(0, 0, 3'd0, 0, 0, 0);
    chk("idle_ended", 32'(test_has_ended), 32'd1);

    $display("[TB] random traffic");
    repeat (2) step(1, 0, 3'd0, 0, 0, 0);
    for (int c = 0; c < 400; c++)
      step(0, $urandom_range(3) != 0, 3'($urandom_range(7)), $urandom_range(19) == 0, 0,
           $urandom_range(2) != 0);
    step(0, 0, 3'd0, 0, 1, $urandom_range(1) != 0);
    n = 0;
    while (m_st != M_ENDED && n < 200) begin
      step(0, 0, 3'd0, 0, 0, $urandom_range(1) != 0);
      n++;
    end
    step(0, 0, 3'd0, 0, 0, 1);
    chk("drain_ended", 32'(test_has_ended), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
